// File: rtl/mux_chk_pkg.sv
// Shared types and default constants for the mux checker/monitor.
package mux_chk_pkg;

    // FSM encoding is visible on the state port, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FAIL  = 2'd2
    } state_t;

    localparam int DEF_W     = 8;
    localparam int DEF_N     = 4;
    localparam int DEF_CNT_W = 8;

    // Select width: max(1, clog2(n)).
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_chk_ref.sv
// Combinational N:1 reference mux with out-of-range select detection.
module mux_chk_ref
    import mux_chk_pkg::*;
#(
    parameter  int W  = DEF_W,
    parameter  int N  = DEF_N,
    localparam int SW = sel_width(N)
) (
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   exp_val,
    output logic           oob
);

    localparam int unsigned NU = N;

    assign oob = (32'(sel) >= NU);

    // Pick the selected channel; an out-of-range select yields zero.
    always_comb begin
        exp_val = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            if (32'(sel) == k) begin
                exp_val = din[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_chk_mon.sv
// Mux checker/monitor: compares an observed mux output against a reference
// selection, flags per-sample errors, counts them, captures the first one and
// tracks an IDLE/CHECK/FAIL state machine.
// Optional build macro: MUX_CHK_MON_ASSERT_EN (error messages and a
// counter-monotonicity property); port behaviour is identical either way.
module mux_chk_mon
    import mux_chk_pkg::*;
#(
    parameter  int W     = DEF_W,
    parameter  int N     = DEF_N,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int SW    = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N*W-1:0]   din,
    input  logic [SW-1:0]    sel,
    input  logic [W-1:0]     y,
    input  logic             clr,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sel_oob,
    output logic [SW-1:0]    first_sel,
    output logic [W-1:0]     first_exp,
    output logic [W-1:0]     first_got,
    output logic [1:0]       state
);

    logic [W-1:0]     exp_val;
    logic             oob;
    logic             sample_err;

    state_t           state_q;
    logic             err_q;
    logic             oob_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SW-1:0]    fsel_q;
    logic [W-1:0]     fexp_q;
    logic [W-1:0]     fgot_q;

    mux_chk_ref #(
        .W (W),
        .N (N)
    ) u_ref (
        .din     (din),
        .sel     (sel),
        .exp_val (exp_val),
        .oob     (oob)
    );

    assign sample_err = in_valid && (oob || (y != exp_val));

    // Checker state: per-sample flags, saturating count, first-error capture
    // and FSM. clr wins over a coincident sample, which is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            oob_q   <= 1'b0;
            cnt_q   <= '0;
            fsel_q  <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
        end else if (clr) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            oob_q   <= 1'b0;
            cnt_q   <= '0;
            fsel_q  <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
        end else begin
            err_q <= sample_err;
            oob_q <= in_valid && oob;

            if (sample_err && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Sticky flag is derived from FAIL, so "not yet in FAIL" is the
            // first-error condition.
            if (sample_err && (state_q != FAIL)) begin
                fsel_q <= sel;
                fexp_q <= exp_val;
                fgot_q <= y;
            end

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= sample_err ? FAIL : CHECK;
                    end
                end
                CHECK: begin
                    if (sample_err) begin
                        state_q <= FAIL;
                    end
                end
                FAIL: begin
                    state_q <= FAIL;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign err        = err_q;
    assign err_sticky = (state_q == FAIL);
    assign err_cnt    = cnt_q;
    assign sel_oob    = oob_q;
    assign first_sel  = fsel_q;
    assign first_exp  = fexp_q;
    assign first_got  = fgot_q;
    assign state      = state_q;

`ifdef MUX_CHK_MON_ASSERT_EN
    // Report every sample error that is actually recorded.
    always @(posedge clk) begin
        if (rst_n && !clr && sample_err) begin
            $error("mux_chk_mon: sample error sel=%0d expected=%h y=%h", sel, exp_val, y);
        end
    end

    // The error counter only ever moves down through clr or reset.
    a_cnt_monotonic: assert property (
        @(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && !$past(clr)) |-> (cnt_q >= $past(cnt_q))
    ) else $error("mux_chk_mon: err_cnt decreased without clr or reset");
`endif

endmodule
